reg_writeback_queue: RTL and testbench
======================================

// Module: reg_writeback_queue
// PURPOSE
//   Write side of the 32-bit register bank. Buffers completed results from the
//   execute/memory stages in a small FIFO and drains them into the bank's
//   write port at one per cycle. Publishes a pending-destination mask for
//   hazard stalls and, optionally, a bypass lookup for operand fetch.
// PARAMETERS
//   WIDTH      32  data width of a result and of a bank register
//   ADD_WIDTH  5   register address width
//   DEPTH      4   FIFO entries; power of 2, >= 2
//   PTR_W      2   log2(DEPTH)
// PORTS
//   clk        in   1          rising-edge clock
//   rst_n      in   1          asynchronous active-low reset
//   flush      in   1          synchronous clear of all buffered results
//   in_valid   in   1          result offered
//   in_ready   out  1          queue can accept
//   in_reg     in   ADD_WIDTH  destination register
//   in_data    in   WIDTH      result value
//   wb_en      out  1          bank write enable (to w_en)
//   wb_reg     out  ADD_WIDTH  bank write address (to w_reg)
//   wb_data    out  WIDTH      bank write data (to w_data)
//   pend_mask  out  2**ADD_WIDTH  bit r = write to r still outstanding
//   count      out  PTR_W+1    entries currently queued (0..DEPTH)
//   byp_reg    in   ADD_WIDTH  bypass lookup address
//   byp_hit    out  1          lookup matched an outstanding write
//   byp_data   out  WIDTH      value of the youngest matching write
// BEHAVIOUR
//   - Reset: queue empty, head/tail = 0, count = 0, wb_en = 0, wb_reg = 0,
//     wb_data = 0, pend_mask = 0, byp_hit = 0, byp_data = 0, in_ready = 1.
//   - in_ready = (count != DEPTH) && !flush (combinational).
//   - Push on in_valid && in_ready. If in_reg == 0, the handshake completes
//     but nothing is enqueued (x0 writes are dropped).
//   - wb_* are registered. On each edge where count != 0 and !flush, the head
//     is popped into wb_en = 1, wb_reg, wb_data. Otherwise wb_en = 0, and
//     wb_reg/wb_data hold their values.
//   - Latency: a result accepted at edge N is driven on wb_* after edge N+1 if
//     the queue was empty. It is committed into the bank at edge N+2.
//   - Simultaneous push and pop: allowed. count is unchanged. A push into an
//     empty queue is not popped at the same edge.
//   - Full: in_ready = 0. Pop at that edge still occurs, so in_ready is 1 on
//     the next cycle.
//   - Pointers wrap modulo DEPTH. count distinguishes full from empty.
//   - pend_mask (combinational) = OR over valid queue entries of their
//     dest bit, OR the wb_reg bit when wb_en = 1. Bit 0 is always 0.
//   - flush has priority over push and pop. At the next edge: count = 0,
//     pointers = 0, wb_en = 0. It does not cancel a wb_en already asserted in
//     the current cycle.
//   - rst_n low mid-operation: all state is cleared immediately. In-flight
//     data is lost and no partial write is issued.
// CONFIGURATION
//   WB_BYPASS_EN defined: byp_hit = 1 if byp_reg != 0 and it matches a valid
//     queue entry or the active wb stage. byp_data comes from the youngest
//     match, by priority: newest queue entry > older entries > wb stage.
//     The purely combinational path excludes the same-cycle in_* input.
//   WB_BYPASS_EN undefined: ports remain present. byp_hit = 0, byp_data = 0,
//     and no compare logic is built.
// TESTING
//   - Reset/idle: rst_n=0 then release -> wb_en=0, count=0, in_ready=1,
//     pend_mask=0.
//   - Single write: push r5=0xDEADBEEF at edge N -> after N+1, wb_en=1,
//     wb_reg=5, wb_data=0xDEADBEEF. pend_mask[5]=1 from N to N+1, then 0 once
//     drained.
//   - Fill: hold off drain, or burst 5 pushes with DEPTH=4 -> in_ready=0
//     only when count=4. Every accepted value drains in order, none lost or
//     duplicated.
//   - x0 drop: push r0=0x1234 -> handshake completes, count stays 0, wb_en
//     never 1.
//   - Flush: queue r1,r2,r3, then flush=1 for one cycle -> count=0,
//     pend_mask=0, and no further wb_en pulses.
//   - Bypass (WB_BYPASS_EN): queue r7=0x11 then r7=0x22, set byp_reg=7 ->
//     byp_hit=1, byp_data=0x22. With byp_reg=0 -> byp_hit=0. Without the
//     macro -> byp_hit=0 always.

Source files
------------

// File: rtl/reg_writeback_queue.sv
// Register-bank writeback queue: buffers results and drains one per cycle into the bank write port.
// Optional operand bypass lookup is built only when WB_BYPASS_EN is defined.
module reg_writeback_queue #(
  parameter int WIDTH     = 32,
  parameter int ADD_WIDTH = 5,
  parameter int DEPTH     = 4,
  parameter int PTR_W     = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADD_WIDTH-1:0]    in_reg,
  input  logic [WIDTH-1:0]        in_data,
  output logic                    wb_en,
  output logic [ADD_WIDTH-1:0]    wb_reg,
  output logic [WIDTH-1:0]        wb_data,
  output logic [2**ADD_WIDTH-1:0] pend_mask,
  output logic [PTR_W:0]          count,
  input  logic [ADD_WIDTH-1:0]    byp_reg,
  output logic                    byp_hit,
  output logic [WIDTH-1:0]        byp_data
);

  localparam logic [PTR_W:0]   FULL     = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [ADD_WIDTH-1:0] q_reg  [DEPTH];
  logic [WIDTH-1:0]     q_data [DEPTH];
  logic [PTR_W-1:0]     head, tail;
  logic [PTR_W:0]       cnt;
  logic                 push, pop;

  assign in_ready = (cnt != FULL) && !flush;
  // x0 writes complete the handshake but are never enqueued
  assign push     = in_valid && in_ready && (in_reg != '0);
  assign pop      = (cnt != '0) && !flush;
  assign count    = cnt;

  always_ff @(posedge clk) begin
    if (push) begin
      q_reg[tail]  <= in_reg;
      q_data[tail] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      cnt     <= '0;
      wb_en   <= 1'b0;
      wb_reg  <= '0;
      wb_data <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      cnt   <= '0;
      wb_en <= 1'b0;
    end else begin
      wb_en <= pop;
      if (pop) begin
        wb_reg  <= q_reg[head];
        wb_data <= q_data[head];
        head    <= head + PTR_ONE;
      end
      if (push)
        tail <= tail + PTR_ONE;
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  logic [PTR_W-1:0] pm_idx;

  always_comb begin
    pend_mask = '0;
    pm_idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      pm_idx = head + PTR_W'(k);
      if ((PTR_W+1)'(k) < cnt)
        pend_mask[q_reg[pm_idx]] = 1'b1;
    end
    if (wb_en)
      pend_mask[wb_reg] = 1'b1;
    pend_mask[0] = 1'b0;
  end

`ifdef WB_BYPASS_EN
  logic [PTR_W-1:0] bp_idx;

  // Walk oldest to newest so the youngest match wins; wb stage is lowest priority.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    bp_idx   = '0;
    if (byp_reg != '0) begin
      if (wb_en && (wb_reg == byp_reg)) begin
        byp_hit  = 1'b1;
        byp_data = wb_data;
      end
      for (int k = 0; k < DEPTH; k++) begin
        bp_idx = head + PTR_W'(k);
        if (((PTR_W+1)'(k) < cnt) && (q_reg[bp_idx] == byp_reg)) begin
          byp_hit  = 1'b1;
          byp_data = q_data[bp_idx];
        end
      end
    end
  end
`else
  logic unused_byp;
  assign unused_byp = ^byp_reg;
  assign byp_hit    = 1'b0;
  assign byp_data   = '0;
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Self-checking bench for reg_writeback_queue: vector table plus scoreboard on the wb port.
module tb_reg_writeback_queue;
  localparam int WIDTH = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [AW-1:0]     in_reg = '0;
  logic [WIDTH-1:0]  in_data = '0;
  logic              wb_en;
  logic [AW-1:0]     wb_reg;
  logic [WIDTH-1:0]  wb_data;
  logic [2**AW-1:0]  pend_mask;
  logic [PTR_W:0]    count;
  logic [AW-1:0]     byp_reg = '0;
  logic              byp_hit;
  logic [WIDTH-1:0]  byp_data;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [AW-1:0] r; logic [WIDTH-1:0] d; } wb_t;
  wb_t exp_q[$];

  typedef struct {
    logic v; logic [AW-1:0] r; logic [WIDTH-1:0] d; logic fl;
    logic e_rdy; logic [PTR_W:0] e_cnt; logic e_wb; logic [AW-1:0] e_wbreg;
  } vec_t;
  vec_t vecs[16];

  always #5 clk = ~clk;

  reg_writeback_queue #(.WIDTH(WIDTH), .ADD_WIDTH(AW), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_reg(in_reg), .in_data(in_data), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .pend_mask(pend_mask), .count(count), .byp_reg(byp_reg), .byp_hit(byp_hit),
    .byp_data(byp_data)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] r, input logic [WIDTH-1:0] d,
                       input logic fl);
    in_valid = v;
    in_reg   = r;
    in_data  = d;
    flush    = fl;
  endtask

  task automatic chk_byp(input string nm, input logic hit, input logic [WIDTH-1:0] d);
`ifdef WB_BYPASS_EN
    chk({nm, "_hit"}, 64'(byp_hit), 64'(hit));
    if (hit) chk({nm, "_data"}, 64'(byp_data), 64'(d));
`else
    chk({nm, "_hit"}, 64'(byp_hit), 64'(1'b0));
    chk({nm, "_data"}, 64'(byp_data), 64'(0));
`endif
  endtask

  // Scoreboard: accepted non-x0 results enter in order; reset and flush discard the backlog.
  always @(posedge clk) begin
    if (!rst_n || flush) exp_q.delete();
    else if (in_valid && in_reg != '0) exp_q.push_back('{in_reg, in_data});
  end

  always @(negedge clk) begin
    wb_t e;
    if (rst_n && wb_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_wb: got write to r%0d data %0h, expected no write",
                 wb_reg, wb_data);
      end else begin
        e = exp_q.pop_front();
        chk("sb_wb_reg", 64'(wb_reg), 64'(e.r));
        chk("sb_wb_data", 64'(wb_data), 64'(e.d));
      end
    end
  end

  initial begin
    vecs[0]  = '{1'b1, 5'd1,  32'hA000_0001, 1'b0, 1'b1, 3'd1, 1'b0, 5'd5};
    vecs[1]  = '{1'b1, 5'd2,  32'hA000_0002, 1'b0, 1'b1, 3'd1, 1'b1, 5'd1};
    vecs[2]  = '{1'b1, 5'd3,  32'hA000_0003, 1'b0, 1'b1, 3'd1, 1'b1, 5'd2};
    vecs[3]  = '{1'b1, 5'd0,  32'h0000_1234, 1'b0, 1'b1, 3'd0, 1'b1, 5'd3};
    vecs[4]  = '{1'b1, 5'd4,  32'hA000_0004, 1'b0, 1'b1, 3'd1, 1'b0, 5'd3};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,         1'b0, 1'b1, 3'd0, 1'b1, 5'd4};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,         1'b0, 1'b1, 3'd0, 1'b0, 5'd4};
    vecs[7]  = '{1'b1, 5'd0,  32'h0000_1234, 1'b0, 1'b1, 3'd0, 1'b0, 5'd4};
    vecs[8]  = '{1'b1, 5'd6,  32'hA000_0006, 1'b1, 1'b0, 3'd0, 1'b0, 5'd4};
    vecs[9]  = '{1'b1, 5'd7,  32'hA000_0007, 1'b0, 1'b1, 3'd1, 1'b0, 5'd4};
    vecs[10] = '{1'b1, 5'd8,  32'hA000_0008, 1'b1, 1'b0, 3'd0, 1'b0, 5'd4};
    vecs[11] = '{1'b0, 5'd0,  32'h0,         1'b0, 1'b1, 3'd0, 1'b0, 5'd4};
    vecs[12] = '{1'b1, 5'd9,  32'hA000_0009, 1'b0, 1'b1, 3'd1, 1'b0, 5'd4};
    vecs[13] = '{1'b1, 5'd10, 32'hA000_000A, 1'b0, 1'b1, 3'd1, 1'b1, 5'd9};
    vecs[14] = '{1'b0, 5'd0,  32'h0,         1'b1, 1'b0, 3'd0, 1'b0, 5'd9};
    vecs[15] = '{1'b0, 5'd0,  32'h0,         1'b0, 1'b1, 3'd0, 1'b0, 5'd9};

    // Reset / idle
    #12 rst_n = 1'b1;
    #1;
    chk("rst_wb_en", 64'(wb_en), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_pend_mask", 64'(pend_mask), 64'(0));
    chk("rst_wb_reg", 64'(wb_reg), 64'(0));
    chk("rst_wb_data", 64'(wb_data), 64'(0));
    chk("rst_byp_hit", 64'(byp_hit), 64'(0));
    chk("rst_byp_data", 64'(byp_data), 64'(0));
    cyc();

    // Single write with pend_mask lifetime
    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0);
    #1 chk("single_pend_excl_input", 64'(pend_mask), 64'(0));
    cyc();
    drive(1'b0, '0, '0, 1'b0);
    #1;
    chk("single_count_n", 64'(count), 64'(1));
    chk("single_wb_en_n", 64'(wb_en), 64'(0));
    chk("single_pend_n", 64'(pend_mask), 64'(32'h0000_0020));
    cyc();
    chk("single_wb_en_n1", 64'(wb_en), 64'(1));
    chk("single_wb_reg_n1", 64'(wb_reg), 64'(5));
    chk("single_wb_data_n1", 64'(wb_data), 64'(32'hDEAD_BEEF));
    chk("single_pend_n1", 64'(pend_mask), 64'(32'h0000_0020));
    cyc();
    chk("single_wb_en_n2", 64'(wb_en), 64'(0));
    chk("single_pend_n2", 64'(pend_mask), 64'(0));

    // Vector table: bursts, x0 drops, flushes
    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].r, vecs[i].d, vecs[i].fl);
      #1 chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].e_rdy));
      cyc();
      chk($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].e_cnt));
      chk($sformatf("vec%0d_wb_en", i), 64'(wb_en), 64'(vecs[i].e_wb));
      chk($sformatf("vec%0d_wb_reg", i), 64'(wb_reg), 64'(vecs[i].e_wbreg));
    end
    drive(1'b0, '0, '0, 1'b0);

    // Flush with r1,r2,r3 in flight
    drive(1'b1, 5'd1, 32'hB1, 1'b0);
    cyc();
    #1 chk("fl_pend_r1", 64'(pend_mask), 64'(32'h2));
    drive(1'b1, 5'd2, 32'hB2, 1'b0);
    cyc();
    #1 chk("fl_pend_r1_r2", 64'(pend_mask), 64'(32'h6));
    drive(1'b1, 5'd3, 32'hB3, 1'b0);
    cyc();
    drive(1'b0, '0, '0, 1'b1);
    #1;
    chk("fl_pend_r2_r3", 64'(pend_mask), 64'(32'hC));
    chk("fl_active_wb_kept", 64'(wb_en), 64'(1));
    chk("fl_in_ready", 64'(in_ready), 64'(0));
    cyc();
    drive(1'b0, '0, '0, 1'b0);
    #1;
    chk("fl_count", 64'(count), 64'(0));
    chk("fl_pend", 64'(pend_mask), 64'(0));
    chk("fl_wb_en", 64'(wb_en), 64'(0));
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk($sformatf("fl_quiet%0d", i), 64'(wb_en), 64'(0));
    end

    // Bypass lookup
    byp_reg = 5'd7;
    #1 chk_byp("byp_empty", 1'b0, '0);
    drive(1'b1, 5'd7, 32'h11, 1'b0);
    cyc();
    drive(1'b1, 5'd7, 32'h22, 1'b0);
    #1 chk_byp("byp_queue_only", 1'b1, 32'h11);
    cyc();
    drive(1'b0, '0, '0, 1'b0);
    #1 chk_byp("byp_youngest", 1'b1, 32'h22);
    byp_reg = 5'd3;
    #1 chk_byp("byp_miss", 1'b0, '0);
    byp_reg = 5'd0;
    #1 chk_byp("byp_x0", 1'b0, '0);
    byp_reg = 5'd7;
    cyc();
    chk_byp("byp_wb_stage", 1'b1, 32'h22);
    cyc();
    chk_byp("byp_wb_idle", 1'b0, '0);
    byp_reg = 5'd0;

    // Asynchronous reset in the middle of traffic
    drive(1'b1, 5'd11, 32'hC11, 1'b0);
    cyc();
    drive(1'b1, 5'd12, 32'hC12, 1'b0);
    cyc();
    drive(1'b0, '0, '0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_wb_en", 64'(wb_en), 64'(0));
    chk("arst_count", 64'(count), 64'(0));
    chk("arst_pend", 64'(pend_mask), 64'(0));
    chk("arst_in_ready", 64'(in_ready), 64'(1));
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("arst_quiet%0d", i), 64'(wb_en), 64'(0));
    end

    chk("sb_drained", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
